// File: rtl/conv_tile_sched.sv
// conv_tile_sched: walks an output feature map in row-major tiles, issuing one engine launch per tile
module conv_tile_sched #(
    parameter int DIM_W     = 16,
    parameter int TILE_ROWS = 8,
    parameter int TILE_COLS = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_start,
    input  logic [DIM_W-1:0] cfg_rows,
    input  logic [DIM_W-1:0] cfg_cols,
    output logic             tile_start,
    output logic [DIM_W-1:0] tile_row_base,
    output logic [DIM_W-1:0] tile_col_base,
    output logic [DIM_W-1:0] tile_rows,
    output logic [DIM_W-1:0] tile_cols,
    input  logic             tile_done,
    input  logic             write_buffer_wait,
    output logic             end_conv,
    output logic             busy
);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_TILE, DRAIN, FINISH} state_t;

    localparam logic [DIM_W:0] TR = (DIM_W+1)'(TILE_ROWS);
    localparam logic [DIM_W:0] TC = (DIM_W+1)'(TILE_COLS);

    state_t           state, state_nx;
    logic [DIM_W-1:0] rows_q, cols_q, row_b, col_b;
    logic [DIM_W-1:0] rows_nx, cols_nx, row_b_nx, col_b_nx;
    logic [DIM_W-1:0] trb_nx, tcb_nx, tr_nx, tc_nx;
    logic             tile_start_nx, end_conv_nx, busy_nx;
    logic             col_wrap, last;
    logic [DIM_W:0]   row_adv;
    logic [DIM_W-1:0] col_adv;

    // Clipped extent: the remaining span when the tile overhangs the map edge, else the nominal size
    function automatic logic [DIM_W-1:0] extent(input logic [DIM_W-1:0] base, input logic [DIM_W-1:0] dim,
                                                input logic [DIM_W:0] t);
        extent = ({1'b0, base} + t >= {1'b0, dim}) ? dim - base : t[DIM_W-1:0];
    endfunction

    // Next tile position in row-major order; sums are one bit wider so they never wrap
    always_comb begin
        col_wrap = {1'b0, col_b} + TC >= {1'b0, cols_q};
        row_adv  = {1'b0, row_b} + (col_wrap ? TR : '0);
        col_adv  = col_wrap ? '0 : col_b + TC[DIM_W-1:0];
        last     = row_adv >= {1'b0, rows_q};
    end

    // Next-state and next-output logic; every output is registered from these values
    always_comb begin
        state_nx      = state;
        rows_nx       = rows_q;
        cols_nx       = cols_q;
        row_b_nx      = row_b;
        col_b_nx      = col_b;
        trb_nx        = tile_row_base;
        tcb_nx        = tile_col_base;
        tr_nx         = tile_rows;
        tc_nx         = tile_cols;
        tile_start_nx = 1'b0;
        end_conv_nx   = 1'b0;
        busy_nx       = busy;
        case (state)
            IDLE: if (op_start) begin
                rows_nx  = cfg_rows;
                cols_nx  = cfg_cols;
                row_b_nx = '0;
                col_b_nx = '0;
                busy_nx  = 1'b1;
                if (cfg_rows == '0 || cfg_cols == '0) state_nx = FINISH;
                else begin
                    state_nx      = ISSUE;
                    tile_start_nx = 1'b1;
                    trb_nx        = '0;
                    tcb_nx        = '0;
                    tr_nx         = extent('0, cfg_rows, TR);
                    tc_nx         = extent('0, cfg_cols, TC);
                end
            end
            ISSUE: state_nx = WAIT_TILE;
            WAIT_TILE: if (tile_done) state_nx = DRAIN;
            DRAIN: if (!write_buffer_wait) begin
                row_b_nx = row_adv[DIM_W-1:0];
                col_b_nx = col_adv;
                if (last) begin
                    state_nx    = FINISH;
                    end_conv_nx = 1'b1;
                end else begin
                    state_nx      = ISSUE;
                    tile_start_nx = 1'b1;
                    trb_nx        = row_adv[DIM_W-1:0];
                    tcb_nx        = col_adv;
                    tr_nx         = extent(row_adv[DIM_W-1:0], rows_q, TR);
                    tc_nx         = extent(col_adv, cols_q, TC);
                end
            end
            // A zero-size job enters without end_conv and spends one extra cycle raising it
            FINISH: if (end_conv) begin
                state_nx = IDLE;
                busy_nx  = 1'b0;
            end else end_conv_nx = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

    // State, tile position and output registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            rows_q        <= '0;
            cols_q        <= '0;
            row_b         <= '0;
            col_b         <= '0;
            tile_row_base <= '0;
            tile_col_base <= '0;
            tile_rows     <= '0;
            tile_cols     <= '0;
            tile_start    <= 1'b0;
            end_conv      <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_nx;
            rows_q        <= rows_nx;
            cols_q        <= cols_nx;
            row_b         <= row_b_nx;
            col_b         <= col_b_nx;
            tile_row_base <= trb_nx;
            tile_col_base <= tcb_nx;
            tile_rows     <= tr_nx;
            tile_cols     <= tc_nx;
            tile_start    <= tile_start_nx;
            end_conv      <= end_conv_nx;
            busy          <= busy_nx;
        end
    end
endmodule
